// File: rtl/display_mux_ctrl_pkg.sv
// Shared types and constants for the 0-19 amount display scan controller.
// Holds the FSM state encoding, digit enable codes and saturation limit.
package display_mux_ctrl_pkg;

    typedef enum logic [1:0] {
        S_ONES    = 2'd0,
        S_BLANK_O = 2'd1,
        S_TENS    = 2'd2,
        S_BLANK_T = 2'd3
    } state_t;

    localparam logic [1:0] DIG_NONE = 2'b00;
    localparam logic [1:0] DIG_ONES = 2'b01;
    localparam logic [1:0] DIG_TENS = 2'b10;

    localparam logic [4:0] AMOUNT_MAX = 5'd19;

endpackage

// File: rtl/display_mux_ctrl_if.sv
// Valid/ready amount channel into the display scan controller.
// master drives amount/in_valid, slave returns in_ready.
interface display_mux_ctrl_if;

    logic       in_valid;
    logic       in_ready;
    logic [4:0] amount;

    modport master (
        output in_valid,
        output amount,
        input  in_ready
    );

    modport slave (
        input  in_valid,
        input  amount,
        output in_ready
    );

endinterface

// File: rtl/display_mux_ctrl_bin_to_bcd.sv
// Combinational 5-bit binary to two-digit BCD for the range 0-19.
// Inputs above 19 saturate to 19 and raise ovf.
module bin_to_bcd_19
    import display_mux_ctrl_pkg::*;
(
    input  logic [4:0] bin,
    output logic [4:0] sat,
    output logic       tens,
    output logic [3:0] ones,
    output logic       ovf
);

    assign ovf  = (bin > AMOUNT_MAX);
    assign sat  = ovf ? AMOUNT_MAX : bin;
    assign tens = (sat >= 5'd10);
    // 10..19 have low nibble A..F,0..3; adding 6 mod 16 yields 0..9
    assign ones = tens ? (sat[3:0] + 4'd6) : sat[3:0];

endmodule

// File: rtl/display_mux_ctrl.sv
// Two-digit scan controller sharing one 7-segment decoder; new amounts apply at frame ends.
// Define DISPLAY_MUX_LEADING_ZERO_BLANK_EN to keep the tens digit dark when it is 0.
module display_mux_ctrl
    import display_mux_ctrl_pkg::*;
#(
    parameter int REFRESH_DIV  = 1000,
    parameter int BLANK_CYCLES = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    display_mux_ctrl_if.slave in_if,
    output logic [3:0]        bcd_data,
    output logic [1:0]        digit_en,
    output logic              overflow
);

    localparam int MAX_LIM = (REFRESH_DIV > BLANK_CYCLES) ? REFRESH_DIV : BLANK_CYCLES;
    localparam int PW      = (MAX_LIM > 1) ? $clog2(MAX_LIM) : 1;

    localparam logic [PW-1:0] REF_LAST = PW'(REFRESH_DIV - 1);
    localparam logic [PW-1:0] BLK_LAST = PW'(BLANK_CYCLES - 1);

    state_t        state_q, state_d;
    logic [PW-1:0] phase_q, phase_d;
    logic          last;

    logic [4:0] shown_q, shown_d;
    logic [4:0] pending_q;
    logic       pending_ovf_q;
    logic       pending_full_q;
    logic       overflow_d;

    logic       take;
    logic       load;

    logic [4:0] in_sat;
    logic       in_ovf;
    logic       unused_in_tens;
    logic [3:0] unused_in_ones;

    logic [4:0] unused_disp_sat;
    logic       unused_disp_ovf;
    logic       disp_tens;
    logic [3:0] disp_ones;

    logic       tens_en;
    logic [1:0] digit_en_d;
    logic [3:0] bcd_d;

    bin_to_bcd_19 u_in_cvt (
        .bin  (in_if.amount),
        .sat  (in_sat),
        .tens (unused_in_tens),
        .ones (unused_in_ones),
        .ovf  (in_ovf)
    );

    // Converts the value that will be on display next cycle
    bin_to_bcd_19 u_disp_cvt (
        .bin  (shown_d),
        .sat  (unused_disp_sat),
        .tens (disp_tens),
        .ones (disp_ones),
        .ovf  (unused_disp_ovf)
    );

`ifdef DISPLAY_MUX_LEADING_ZERO_BLANK_EN
    assign tens_en = disp_tens;
`else
    assign tens_en = 1'b1;
`endif

    assign in_if.in_ready = !pending_full_q;
    assign take           = in_if.in_valid && !pending_full_q;

    always_comb begin
        state_d = state_q;
        phase_d = phase_q + PW'(1);
        last    = 1'b0;
        unique case (state_q)
            S_ONES: begin
                last = (phase_q == REF_LAST);
                if (last) state_d = S_BLANK_O;
            end
            S_BLANK_O: begin
                last = (phase_q == BLK_LAST);
                if (last) state_d = S_TENS;
            end
            S_TENS: begin
                last = (phase_q == REF_LAST);
                if (last) state_d = S_BLANK_T;
            end
            S_BLANK_T: begin
                last = (phase_q == BLK_LAST);
                if (last) state_d = S_ONES;
            end
            default: state_d = S_ONES;
        endcase
        if (last) phase_d = '0;
    end

    // pending_full blocks take, so load and take are never both set
    assign load       = (state_q == S_BLANK_T) && last && pending_full_q;
    assign shown_d    = load ? pending_q : shown_q;
    assign overflow_d = load ? pending_ovf_q : overflow;

    always_comb begin
        digit_en_d = DIG_NONE;
        bcd_d      = bcd_data;
        unique case (state_d)
            S_ONES: begin
                digit_en_d = DIG_ONES;
                bcd_d      = disp_ones;
            end
            S_TENS: begin
                digit_en_d = tens_en ? DIG_TENS : DIG_NONE;
                bcd_d      = {3'b000, disp_tens};
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_ONES;
            phase_q <= '0;
        end else begin
            state_q <= state_d;
            phase_q <= phase_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pending_q      <= '0;
            pending_ovf_q  <= 1'b0;
            pending_full_q <= 1'b0;
        end else if (take) begin
            pending_q      <= in_sat;
            pending_ovf_q  <= in_ovf;
            pending_full_q <= 1'b1;
        end else if (load) begin
            pending_full_q <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shown_q  <= '0;
            overflow <= 1'b0;
            digit_en <= DIG_ONES;
            bcd_data <= 4'd0;
        end else begin
            shown_q  <= shown_d;
            overflow <= overflow_d;
            digit_en <= digit_en_d;
            bcd_data <= bcd_d;
        end
    end

endmodule

// File: tb/tb_display_mux_ctrl.sv
// Bench for display_mux_ctrl with REFRESH_DIV=4, BLANK_CYCLES=2 (12-cycle frame).
// Reference model tracks frame position and shown/pending amounts directly.
module tb_display_mux_ctrl;

    localparam int RD    = 4;
    localparam int BC    = 2;
    localparam int FRAME = 2 * (RD + BC);

    logic       clk = 1'b0;
    logic       rst_n;
    logic [3:0] bcd_data;
    logic [1:0] digit_en;
    logic       overflow;

    display_mux_ctrl_if bus ();

    display_mux_ctrl #(
        .REFRESH_DIV  (RD),
        .BLANK_CYCLES (BC)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_if    (bus),
        .bcd_data (bcd_data),
        .digit_en (digit_en),
        .overflow (overflow)
    );

    always #5 clk = ~clk;

    int compared   = 0;
    int mismatched = 0;

    int pos;
    int m_shown;
    int m_pend;
    bit m_pf;
    bit m_ovf;
    bit m_povf;
    int xfers;

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [1:0] exp_en();
        if (pos < RD) return 2'b01;
        if (pos >= RD + BC && pos < 2 * RD + BC) begin
`ifdef DISPLAY_MUX_LEADING_ZERO_BLANK_EN
            if (m_shown < 10) return 2'b00;
`endif
            return 2'b10;
        end
        return 2'b00;
    endfunction

    // blanks keep the digit value lit just before them
    function automatic int exp_bcd();
        if (pos < RD + BC) return m_shown % 10;
        return m_shown / 10;
    endfunction

    task automatic model_reset();
        pos     = 0;
        m_shown = 0;
        m_pend  = 0;
        m_pf    = 0;
        m_ovf   = 0;
        m_povf  = 0;
    endtask

    task automatic step(input logic v, input logic [4:0] a);
        check("digit_en", 8'(digit_en), 8'(exp_en()));
        check("bcd_data", 8'(bcd_data), 8'(exp_bcd()));
        check("overflow", 8'(overflow), 8'(m_ovf));
        check("in_ready", 8'(bus.in_ready), 8'(!m_pf));
        if (v && bus.in_ready) xfers++;
        bus.in_valid = v;
        bus.amount   = a;
        if (pos == FRAME - 1 && m_pf) begin
            m_shown = m_pend;
            m_ovf   = m_povf;
            m_pf    = 0;
        end else if (v && !m_pf) begin
            m_pend = (a > 19) ? 19 : int'(a);
            m_povf = (a > 19);
            m_pf   = 1;
        end
        pos = (pos + 1) % FRAME;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 5'($urandom_range(0, 31)));
    endtask

    initial begin
        rst_n        = 1'b0;
        bus.in_valid = 1'b0;
        bus.amount   = 5'd0;
        model_reset();
        repeat (2) @(negedge clk);
        check("rst_digit_en", 8'(digit_en), 8'h01);
        check("rst_bcd", 8'(bcd_data), 8'h00);
        check("rst_ready", 8'(bus.in_ready), 8'h01);
        check("rst_ovf", 8'(overflow), 8'h00);
        rst_n = 1'b1;

        // scan sequence with 17
        step(1'b1, 5'd17);
        idle(3 * FRAME);

        // saturation then clear
        step(1'b1, 5'd25);
        idle(2 * FRAME);
        step(1'b1, 5'd3);
        idle(2 * FRAME);

        // back-to-back 5 then 12, 12 held until accepted
        step(1'b1, 5'd5);
        for (int i = 0; i < 3 * FRAME && m_pf; i++) step(1'b1, 5'd12);
        step(1'b1, 5'd12);
        idle(2 * FRAME);

        // leading zero case
        step(1'b1, 5'd7);
        idle(2 * FRAME);

        // continuous valid: one transfer per frame
        while (pos != 0) step(1'b0, 5'd0);
        for (int f = 0; f < 6; f++) begin
            xfers = 0;
            for (int c = 0; c < FRAME; c++) step(1'b1, 5'($urandom_range(0, 31)));
            check("xfer_per_frame", 8'(xfers), 8'd1);
        end

        // random traffic
        for (int i = 0; i < 300; i++)
            step(($urandom_range(0, 3) == 0), 5'($urandom_range(0, 31)));

        // asynchronous reset mid-S_TENS with a value pending
        for (int i = 0; i < 100 && !(pos == RD + BC + 1 && m_pf); i++)
            step(1'b1, 5'($urandom_range(10, 31)));
        check("reach_tens_pending", 8'(pos == RD + BC + 1 && m_pf), 8'd1);
        bus.in_valid = 1'b0;
        #1 rst_n = 1'b0;
        #1;
        check("mid_rst_digit_en", 8'(digit_en), 8'h01);
        check("mid_rst_bcd", 8'(bcd_data), 8'h00);
        check("mid_rst_ready", 8'(bus.in_ready), 8'h01);
        check("mid_rst_ovf", 8'(overflow), 8'h00);
        model_reset();
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        idle(FRAME);
        for (int i = 0; i < 100; i++)
            step(($urandom_range(0, 1) == 0), 5'($urandom_range(0, 31)));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
